// File: rtl/fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared definitions for the FIR MAC sequencer.
//   fir_ctrl_state_t : sequencer FSM states
//   addr_w(n)        : delay-line address width for n taps
//   coef_w(n)        : coefficient index width for n taps (symmetric, n/2 coefs)
//   cnt_w(n)         : width of a counter spanning 0..n-1, at least 1 bit
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_MAC,
      ST_DRAIN,
      ST_OUT
   } fir_ctrl_state_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned addr_w(input int unsigned num_taps);
      return cnt_w(num_taps);
   endfunction

   function automatic int unsigned coef_w(input int unsigned num_taps);
      return cnt_w(num_taps / 2);
   endfunction

endpackage

// File: rtl/fir_addr_gen.sv
// -----------------------------------------------------------------------------
// fir_addr_gen
// Pointer and address generation for the FIR MAC sequencer. Holds the clear
// sweep index, the delay-line write pointer, the base (newest sample) address
// and the tap-pair index k. All arithmetic wraps modulo NUM_TAPS by plain
// AW-bit truncation.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-low reset
//   sweep_step_i  in   advance the clear sweep index
//   accept_i      in   sample accepted: base<=wptr, wptr++, k<=0
//   mac_step_i    in   advance k
//   sweep_idx_o   out  current clear sweep address
//   sweep_last_o  out  sweep index is at the last address
//   wptr_o        out  delay-line write pointer
//   rd_addr_a_o   out  (base - k) mod NUM_TAPS
//   rd_addr_b_o   out  (base + 1 + k) mod NUM_TAPS
//   coef_addr_o   out  k
//   k_first_o     out  k == 0
//   k_last_o      out  k == NUM_TAPS/2 - 1
// -----------------------------------------------------------------------------
module fir_addr_gen
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned NUM_TAPS = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sweep_step_i,
   input  logic                          accept_i,
   input  logic                          mac_step_i,
   output logic [addr_w(NUM_TAPS)-1:0]   sweep_idx_o,
   output logic                          sweep_last_o,
   output logic [addr_w(NUM_TAPS)-1:0]   wptr_o,
   output logic [addr_w(NUM_TAPS)-1:0]   rd_addr_a_o,
   output logic [addr_w(NUM_TAPS)-1:0]   rd_addr_b_o,
   output logic [coef_w(NUM_TAPS)-1:0]   coef_addr_o,
   output logic                          k_first_o,
   output logic                          k_last_o
);

   localparam int unsigned AW = addr_w(NUM_TAPS);
   localparam int unsigned CW = coef_w(NUM_TAPS);

   logic [AW-1:0] sweep_q, sweep_d;
   logic [AW-1:0] wptr_q,  wptr_d;
   logic [AW-1:0] base_q,  base_d;
   logic [CW-1:0] k_q,     k_d;
   logic [AW-1:0] k_ext;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sweep_q <= '0;
         wptr_q  <= '0;
         base_q  <= '0;
         k_q     <= '0;
      end else begin
         sweep_q <= sweep_d;
         wptr_q  <= wptr_d;
         base_q  <= base_d;
         k_q     <= k_d;
      end
   end

   // The sweep index wraps back to 0 after the last address, so it is already
   // primed for the next clear without a separate reload.
   always_comb begin
      sweep_d = sweep_q;
      wptr_d  = wptr_q;
      base_d  = base_q;
      k_d     = k_q;
      if (sweep_step_i) begin
         sweep_d = sweep_q + 1'b1;
      end
      if (accept_i) begin
         base_d = wptr_q;
         wptr_d = wptr_q + 1'b1;
         k_d    = '0;
      end else if (mac_step_i) begin
         k_d = k_q + 1'b1;
      end
   end

   assign k_ext        = AW'(k_q);
   assign sweep_idx_o  = sweep_q;
   assign sweep_last_o = (sweep_q == '1);
   assign wptr_o       = wptr_q;
   assign rd_addr_a_o  = base_q - k_ext;
   assign rd_addr_b_o  = base_q + AW'(1) + k_ext;
   assign coef_addr_o  = k_q;
   assign k_first_o    = (k_q == '0);
   assign k_last_o     = (k_q == '1);

endmodule

// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
// Control sequencer for a symmetric FIR filter built around a circular delay
// line and a single pre-add/multiply/accumulate unit. After reset the delay
// line is cleared, then each accepted sample is written at the write pointer
// and NUM_TAPS/2 MAC cycles pair the newest-side and oldest-side taps. After
// PIPE_LAT drain cycles the result is presented until the consumer accepts it.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   new sample offered
//   in_ready   out  sample accepted when in_valid && in_ready (IDLE only)
//   wr_en      out  delay-line write strobe
//   wr_zero    out  write zero instead of the sample (clear sweep)
//   wr_addr    out  delay-line write address
//   rd_addr_a  out  newer-side tap address
//   rd_addr_b  out  older-side tap address
//   coef_addr  out  coefficient index
//   acc_clr    out  load accumulator instead of adding (first MAC cycle)
//   mac_en     out  pre-add/multiply/accumulate enable
//   out_valid  out  filter result valid
//   out_ready  in   downstream accepts result
//   busy       out  sequencer not idle
// -----------------------------------------------------------------------------
module fir_mac_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned NUM_TAPS = 16,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          wr_en,
   output logic                          wr_zero,
   output logic [addr_w(NUM_TAPS)-1:0]   wr_addr,
   output logic [addr_w(NUM_TAPS)-1:0]   rd_addr_a,
   output logic [addr_w(NUM_TAPS)-1:0]   rd_addr_b,
   output logic [coef_w(NUM_TAPS)-1:0]   coef_addr,
   output logic                          acc_clr,
   output logic                          mac_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy
);

   localparam int unsigned AW = addr_w(NUM_TAPS);
   localparam int unsigned CW = coef_w(NUM_TAPS);
   localparam int unsigned DW = cnt_w(PIPE_LAT);

   fir_ctrl_state_t state_q, state_d;
   logic [DW-1:0]   drain_q, drain_d;

   logic          sweep_step, accept, mac_step;
   logic [AW-1:0] sweep_idx, wptr, rd_a, rd_b;
   logic [CW-1:0] coef;
   logic          sweep_last, k_first, k_last;

   logic          in_ready_c, wr_en_c, wr_zero_c, acc_clr_c, mac_en_c, out_valid_c;
   logic [AW-1:0] wr_addr_c;

   fir_addr_gen #(
      .NUM_TAPS (NUM_TAPS)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .sweep_step_i (sweep_step),
      .accept_i     (accept),
      .mac_step_i   (mac_step),
      .sweep_idx_o  (sweep_idx),
      .sweep_last_o (sweep_last),
      .wptr_o       (wptr),
      .rd_addr_a_o  (rd_a),
      .rd_addr_b_o  (rd_b),
      .coef_addr_o  (coef),
      .k_first_o    (k_first),
      .k_last_o     (k_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_CLEAR;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      sweep_step  = 1'b0;
      accept      = 1'b0;
      mac_step    = 1'b0;
      in_ready_c  = 1'b0;
      wr_en_c     = 1'b0;
      wr_zero_c   = 1'b0;
      wr_addr_c   = '0;
      acc_clr_c   = 1'b0;
      mac_en_c    = 1'b0;
      out_valid_c = 1'b0;

      unique case (state_q)
         ST_CLEAR: begin
            wr_en_c    = 1'b1;
            wr_zero_c  = 1'b1;
            wr_addr_c  = sweep_idx;
            sweep_step = 1'b1;
            if (sweep_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            in_ready_c = 1'b1;
            if (in_valid) begin
               wr_en_c   = 1'b1;
               wr_addr_c = wptr;
               accept    = 1'b1;
               state_d   = ST_MAC;
            end
         end
         ST_MAC: begin
            mac_en_c  = 1'b1;
            acc_clr_c = k_first;
            mac_step  = 1'b1;
            if (k_last) begin
               drain_d = '0;
               state_d = (PIPE_LAT == 0) ? ST_OUT : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == DW'(PIPE_LAT - 1)) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            out_valid_c = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Outputs are forced low combinationally while reset is held so nothing
   // leaks out during the reset cycle itself, not just after the next edge.
   assign in_ready  = rst & in_ready_c;
   assign wr_en     = rst & wr_en_c;
   assign wr_zero   = rst & wr_zero_c;
   assign wr_addr   = rst ? wr_addr_c : '0;
   assign rd_addr_a = rst ? rd_a : '0;
   assign rd_addr_b = rst ? rd_b : '0;
   assign coef_addr = rst ? coef : '0;
   assign acc_clr   = rst & acc_clr_c;
   assign mac_en    = rst & mac_en_c;
   assign out_valid = rst & out_valid_c;
   assign busy      = rst & (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

   localparam int NT = 8;
   localparam int PL = 2;
   localparam int HALF = NT / 2;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic       in_ready, wr_en, wr_zero, acc_clr, mac_en, out_valid, busy;
   logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
   logic [1:0] coef_addr;

   always #5 clk = ~clk;

   fir_mac_sequencer #(
      .NUM_TAPS (NT),
      .PIPE_LAT (PL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_zero   (wr_zero),
      .wr_addr   (wr_addr),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .coef_addr (coef_addr),
      .acc_clr   (acc_clr),
      .mac_en    (mac_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   int errs   = 0;
   int checks = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: cycle-count view of a transaction.
   //   clr_left : clear writes still owed after reset
   //   ph       : -1 when waiting for a sample, else cycles elapsed since accept
   //   mem      : id of the sample held at each delay-line slot (0 = cleared)
   int clr_left = NT;
   int ph       = -1;
   int wptr     = 0;
   int base     = 0;
   int nsamp    = 0;
   int mem [NT];

   task automatic cyc(input bit r, input bit iv, input bit ordy);
      int e_ir, e_we, e_wz, e_wa, e_me, e_ac, e_ov, e_busy;
      int k, ea, eb;
      @(negedge clk);
      rst = r; in_valid = iv; out_ready = ordy;
      #1;
      e_ir = 0; e_we = 0; e_wz = 0; e_wa = 0; e_me = 0; e_ac = 0; e_ov = 0; e_busy = 0;
      k = 0;
      if (!r) begin
         // all zero
      end else if (clr_left > 0) begin
         e_we = 1; e_wz = 1; e_wa = NT - clr_left; e_busy = 1;
      end else if (ph < 0) begin
         e_ir = 1;
         if (iv) begin e_we = 1; e_wa = wptr; end
      end else if (ph <= HALF) begin
         k = ph - 1; e_me = 1; e_ac = (k == 0); e_busy = 1;
      end else if (ph <= HALF + PL) begin
         e_busy = 1;
      end else begin
         e_ov = 1; e_busy = 1;
      end

      check_val("in_ready", in_ready, e_ir);
      check_val("wr_en", wr_en, e_we);
      check_val("mac_en", mac_en, e_me);
      check_val("acc_clr", acc_clr, e_ac);
      check_val("out_valid", out_valid, e_ov);
      check_val("busy", busy, e_busy);
      if (e_we || !r) begin
         check_val("wr_zero", wr_zero, (clr_left > 0 && r) ? 1 : 0);
         check_val("wr_addr", wr_addr, e_wa);
      end
      if (!r) begin
         check_val("rst_rd_a", rd_addr_a, 0);
         check_val("rst_rd_b", rd_addr_b, 0);
         check_val("rst_coef", coef_addr, 0);
      end
      if (e_me) begin
         check_val("rd_addr_a", rd_addr_a, (base - k + NT) % NT);
         check_val("rd_addr_b", rd_addr_b, (base + 1 + k) % NT);
         check_val("coef_addr", coef_addr, k);
         // Tap pairing: newest-k pairs with oldest+k of the window.
         ea = (nsamp - k > 0) ? nsamp - k : 0;
         eb = (nsamp - (NT - 1 - k) > 0) ? nsamp - (NT - 1 - k) : 0;
         check_val("tap_a_sample", mem[rd_addr_a], ea);
         check_val("tap_b_sample", mem[rd_addr_b], eb);
      end

      // advance model across the coming edge
      if (!r) begin
         clr_left = NT; ph = -1; wptr = 0; base = 0; nsamp = 0;
      end else if (clr_left > 0) begin
         mem[NT - clr_left] = 0;
         clr_left--;
      end else if (ph < 0) begin
         if (iv) begin
            nsamp++;
            mem[wptr] = nsamp;
            base = wptr;
            wptr = (wptr + 1) % NT;
            ph = 1;
         end
      end else if (ph <= HALF + PL) begin
         ph++;
      end else if (ordy) begin
         ph = -1;
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      foreach (mem[i]) mem[i] = 0;

      repeat (3) cyc(1'b0, 1'b1, 1'b1);
      // clear sweep with in_valid held high: must be ignored
      repeat (NT) cyc(1'b1, 1'b1, 1'b1);
      // first sample, then result held with out_ready low while in_valid pushes
      cyc(1'b1, 1'b1, 1'b0);
      repeat (14) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      // back-to-back samples through the write-pointer wrap
      for (int i = 0; i < 400 && nsamp < 11; i++) cyc(1'b1, 1'b1, 1'b1);
      check_val("samples_reached", nsamp, 11);
      // reset while MAC is at k=2
      for (int i = 0; i < 60 && ph != 3; i++) cyc(1'b1, 1'b1, 1'b1);
      check_val("reach_k2", ph, 3);
      cyc(1'b0, 1'b0, 1'b1);
      repeat (NT + 2) cyc(1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 40);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line:
- NUM_TAPS, 16, filter length; power of two, >= 4.
- PIPE_LAT, 2, cycles from mac_en to accumulator update.
REQ-002 The block SHALL have ports, one per line; AW = $clog2(NUM_TAPS), CW = $clog2(NUM_TAPS/2):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  new sample offered.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- wr_en  out  1  delay-line write strobe.
- wr_zero  out  1  write zero instead of sample (clear sweep).
- wr_addr  out  AW  delay-line write address.
- rd_addr_a  out  AW  newer-side tap address.
- rd_addr_b  out  AW  older-side tap address.
- coef_addr  out  CW  coefficient index.
- acc_clr  out  1  load accumulator instead of adding.
- mac_en  out  1  pre-add/multiply/accumulate enable.
- out_valid  out  1  filter result valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  state != IDLE.

Function
REQ-003 States SHALL be CLEAR, IDLE, MAC, DRAIN, OUT.
REQ-004 CLEAR: wr_en=1, wr_zero=1, wr_addr sweeps 0..NUM_TAPS-1, one per cycle; after last address go IDLE; in_ready=0.
REQ-005 IDLE: in_ready=1; on in_valid: wr_en=1, wr_zero=0, wr_addr=wptr (same cycle); base<=wptr; wptr<=wptr+1 mod NUM_TAPS; k<=0; go MAC.
REQ-006 MAC, k=0..NUM_TAPS/2-1, one per cycle: mac_en=1; rd_addr_a=(base-k) mod NUM_TAPS; rd_addr_b=(base+1+k) mod NUM_TAPS; coef_addr=k; acc_clr=1 only at k=0; after k=NUM_TAPS/2-1 go DRAIN.
REQ-007 DRAIN: mac_en=0 for exactly PIPE_LAT cycles, then OUT.
REQ-008 OUT: out_valid=1, held until out_ready sampled high; that cycle out_valid drops next edge and state goes IDLE.
REQ-009 Latency: sample accepted at cycle t -> out_valid first high at t+NUM_TAPS/2+PIPE_LAT+1.
REQ-010 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored, not queued.
REQ-011 All address arithmetic SHALL be AW-bit unsigned truncation (wrap natural since NUM_TAPS power of two).
REQ-012 wr_en, mac_en, acc_clr, out_valid SHALL be 0 whenever not explicitly asserted above; read/coef addresses are don't-care when mac_en=0.

Reset
REQ-013 While rst=0 at a clock edge: state<=CLEAR, sweep index<=0, wptr<=0, base<=0, k<=0.
REQ-014 While rst=0 all outputs SHALL be 0 (in_ready, wr_en, out_valid included).
REQ-015 Reset mid-operation SHALL abandon the sample; no out_valid; full CLEAR sweep reruns after release.

Structure
REQ-016 Package fir_ctrl_pkg SHALL hold the state enum (fir_ctrl_state_t) and shared width helpers.
REQ-017 Pointer/address generation SHALL be one sub-module fir_addr_gen (wptr, base, k, mod arithmetic); FSM stays in the top.

Verification (NUM_TAPS=8, PIPE_LAT=2)
REQ-018 Release rst -> 8 cycles wr_en=1, wr_zero=1, wr_addr 0..7, in_ready=0; in_ready=1 on 9th cycle.
REQ-019 First sample at t -> wr_addr=0; t+1..t+4: rd_addr_a 0,7,6,5; rd_addr_b 1,2,3,4; coef 0..3; acc_clr at t+1 only; out_valid at t+7.
REQ-020 Ninth sample (base=0 again after 8 writes wrap; test 8th sample, base=7) -> rd_addr_a 7,6,5,4; rd_addr_b 0,1,2,3.
REQ-021 out_ready low 5 cycles in OUT -> out_valid held 5+ cycles, in_ready=0, concurrent in_valid not accepted; accepted first IDLE cycle.
REQ-022 rst=0 during MAC k=2 -> next edge all outputs 0; no out_valid; 8-cycle CLEAR sweep after release.
